// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
// Build option SPI_ARB_RR_EN selects round-robin instead of fixed-priority arbitration.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } spi_arb_state_t;

  // Idle slave-select is all-ones; sliced down to SS_W at the point of use.
  localparam int SS_W_MAX = 16;
  localparam logic [SS_W_MAX-1:0] SS_IDLE = '1;

  function automatic bit is_idle(spi_arb_state_t s);
    return s == IDLE;
  endfunction

endpackage

// File: rtl/spi_req_arbiter.sv
// Request arbiter: picks one winner from req, returning one-hot and index forms.
// SPI_ARB_RR_EN defined: round-robin with pointer register; undefined: lowest index wins.
module spi_req_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     upd,
  output logic                     any,
  output logic [N_REQ-1:0]         gnt_oh,
  output logic [$clog2(N_REQ)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N_REQ);

`ifdef SPI_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;
  logic             found;
  int               j;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= IDX_W'(N_REQ - 1);
    end else if (upd) begin
      ptr_q <= gnt_idx;
    end
  end

  // Search starts one past the last winner and wraps around.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(ptr_q) + k) % N_REQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst, upd};

  always_comb begin
    gnt_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) gnt_idx = IDX_W'(i);
    end
  end
`endif

  assign any    = |req;
  assign gnt_oh = any ? (N_REQ'(1) << gnt_idx) : '0;

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between N_REQ requesters: arbitrate, load, count WIDTH shifts, complete.
// Arbitration policy selected by SPI_ARB_RR_EN (round-robin) or its absence (fixed priority).
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int SS_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WIDTH-1:0]  tx_data,
  input  logic [N_REQ*SS_W-1:0]   tx_ss,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [WIDTH-1:0]        rx_data,
  output logic                    busy,
  output logic                    m_up_data,
  output logic [WIDTH-1:0]        m_data,
  output logic [SS_W-1:0]         m_ss,
  input  logic [WIDTH-1:0]        m_rx_data
);

  // state | meaning
  // IDLE  | arbitrate; latch winner word/code on any request
  // LOAD  | one-cycle parallel-load strobe to the master
  // SHIFT | WIDTH cycles while the master shifts
  // DONE  | capture received word, pulse done to winner

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [SS_W-1:0]  SS_NONE  = SS_IDLE[SS_W-1:0];

  spi_arb_state_t    state_q, state_d;
  logic [N_REQ-1:0]  oh_q;
  logic [WIDTH-1:0]  data_q;
  logic [SS_W-1:0]   ss_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  rx_q;

  logic              arb_any;
  logic              arb_upd;
  logic [N_REQ-1:0]  arb_oh;
  logic [IDX_W-1:0]  arb_idx;

  assign arb_upd = is_idle(state_q) && arb_any;

  spi_req_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .upd     (arb_upd),
    .any     (arb_any),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      oh_q    <= '0;
      data_q  <= '0;
      ss_q    <= SS_NONE;
      cnt_q   <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            oh_q   <= arb_oh;
            data_q <= tx_data[int'(arb_idx)*WIDTH +: WIDTH];
            ss_q   <= tx_ss[int'(arb_idx)*SS_W +: SS_W];
          end
        end
        LOAD:    cnt_q <= '0;
        SHIFT:   cnt_q <= cnt_q + 1'b1;
        DONE:    rx_q  <= m_rx_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_any) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Everything the master and clients see derives from state and latched copies only.
  always_comb begin
    busy      = !is_idle(state_q);
    m_up_data = (state_q == LOAD);
    m_data    = data_q;
    m_ss      = busy ? ss_q : SS_NONE;
    gnt       = busy ? oh_q : '0;
    done      = (state_q == DONE) ? oh_q : '0;
    rx_data   = (state_q == DONE) ? m_rx_data : rx_q;
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: expected loads/completions queued at stimulus time,
// popped and compared by a negedge monitor whenever the DUT strobes m_up_data or done.
module tb_spi_arbiter;

  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    logic [S-1:0] ss;
    int           cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   tx_data = '0;
  logic [N*S-1:0]   tx_ss = '0;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic [W-1:0]     rx_data;
  logic             busy;
  logic             m_up_data;
  logic [W-1:0]     m_data;
  logic [S-1:0]     m_ss;
  logic [W-1:0]     m_rx_data;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  exp_t load_q[$];
  exp_t done_q[$];

  spi_arbiter #(.WIDTH(W), .N_REQ(N), .SS_W(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .tx_data   (tx_data),
    .tx_ss     (tx_ss),
    .gnt       (gnt),
    .done      (done),
    .rx_data   (rx_data),
    .busy      (busy),
    .m_up_data (m_up_data),
    .m_data    (m_data),
    .m_ss      (m_ss),
    .m_rx_data (m_rx_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] rxf(int c);
    return W'(c * 37 + 17);
  endfunction

  assign m_rx_data = rxf(cyc);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_load(int idx, logic [W-1:0] d, logic [S-1:0] s, int c);
    exp_t e;
    e.idx = idx; e.data = d; e.ss = s; e.cyc = c;
    load_q.push_back(e);
  endtask

  task automatic push_done(int idx, int c);
    exp_t e;
    e.idx = idx; e.data = rxf(c); e.ss = '0; e.cyc = c;
    done_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (m_up_data !== 1'b0) begin
        if (load_q.size() == 0) begin
          chk("load_unexpected", 32'(m_up_data), 32'd0);
        end else begin
          e = load_q.pop_front();
          chk("load_cycle", 32'(cyc), 32'(e.cyc));
          chk("load_data", 32'(m_data), 32'(e.data));
          chk("load_ss", 32'(m_ss), 32'(e.ss));
          chk("load_gnt", 32'(gnt), 32'(1) << e.idx);
        end
      end
      if (done !== '0) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'd0);
        end else begin
          e = done_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("done_vec", 32'(done), 32'(1) << e.idx);
          chk("done_gnt", 32'(gnt), 32'(1) << e.idx);
          chk("done_rx", 32'(rx_data), 32'(e.data));
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int c0;
    int c1;
    int w;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_up", 32'(m_up_data), 32'd0);
    chk("rst_mdata", 32'(m_data), 32'd0);
    chk("rst_mss", 32'(m_ss), 32'd3);
    chk("rst_rx", 32'(rx_data), 32'd0);
    rst = 1'b1;
    mon_en = 1'b1;

    // Single request
    tx_data[0*W +: W] = 8'hA5;
    tx_ss[0*S +: S]   = 2'b01;
    c0 = cyc;
    req = 4'b0001;
    push_load(0, 8'hA5, 2'b01, c0 + 1);
    push_done(0, c0 + 10);
    repeat (5) @(negedge clk);
    chk("shift_busy", 32'(busy), 32'd1);
    chk("shift_ss", 32'(m_ss), 32'd1);
    chk("shift_up", 32'(m_up_data), 32'd0);
    repeat (5) @(negedge clk);
    req = '0;
    @(negedge clk);
    chk("idle_ss", 32'(m_ss), 32'd3);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gnt", 32'(gnt), 32'd0);

    // All four requesting continuously
    do_reset();
    for (int i = 0; i < N; i++) begin
      tx_data[i*W +: W] = W'(8'h11 * (i + 1));
      tx_ss[i*S +: S]   = S'(i + 1);
    end
    c0 = cyc;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
`ifdef SPI_ARB_RR_EN
      w = k % N;
`else
      w = 0;
`endif
      push_load(w, W'(8'h11 * (w + 1)), S'(w + 1), c0 + 11 * k + 1);
      push_done(w, c0 + 11 * k + 10);
    end
    repeat (54) @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);

    // Request dropped mid-transfer still completes
    do_reset();
    tx_data[2*W +: W] = 8'h3C;
    tx_ss[2*S +: S]   = 2'b10;
    c0 = cyc;
    req = 4'b0100;
    push_load(2, 8'h3C, 2'b10, c0 + 1);
    push_done(2, c0 + 10);
    repeat (5) @(negedge clk);
    req = '0;
    repeat (6) @(negedge clk);
    chk("drop_idle_busy", 32'(busy), 32'd0);

    // Reset mid-transfer, then a fresh transfer
    do_reset();
    tx_data[0*W +: W] = 8'h77;
    tx_ss[0*S +: S]   = 2'b01;
    c0 = cyc;
    req = 4'b0001;
    push_load(0, 8'h77, 2'b01, c0 + 1);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_ss", 32'(m_ss), 32'd3);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_up", 32'(m_up_data), 32'd0);
    rst = 1'b1;
    tx_data[1*W +: W] = 8'hC3;
    tx_ss[1*S +: S]   = 2'b00;
    c1 = cyc;
    req = 4'b0010;
    push_load(1, 8'hC3, 2'b00, c1 + 1);
    push_done(1, c1 + 10);
    repeat (10) @(negedge clk);
    req = '0;
    @(negedge clk);

    // Inputs changed during SHIFT do not disturb the transfer
    do_reset();
    tx_data[3*W +: W] = 8'h5A;
    tx_ss[3*S +: S]   = 2'b00;
    c0 = cyc;
    req = 4'b1000;
    push_load(3, 8'h5A, 2'b00, c0 + 1);
    push_done(3, c0 + 10);
    repeat (4) @(negedge clk);
    tx_data = '1;
    tx_ss   = '1;
    for (int k = 5; k <= 9; k++) begin
      @(negedge clk);
      chk("hold_mdata", 32'(m_data), 32'h5A);
      chk("hold_mss", 32'(m_ss), 32'd0);
    end
    @(negedge clk);
    req = '0;
    @(negedge clk);
    chk("idle_mdata_held", 32'(m_data), 32'h5A);
    chk("idle_mss_final", 32'(m_ss), 32'd3);

    repeat (2) @(negedge clk);
    chk("load_q_left", 32'(load_q.size()), 32'd0);
    chk("done_q_left", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Transaction controller that shares a single SPI master shift engine between `N_REQ` requesters. It arbitrates pending requests and issues the one-cycle parallel-load pulse with the winner's word and slave-select code. It then counts out `WIDTH` shift cycles, captures the received word, and returns a one-cycle completion pulse to the winner. It sits between the bus-side clients and the SPI master, and owns that master's `up_data`, `data` and `top_ss` inputs.

## Interface
- `WIDTH`, 8: SPI word width in bits; must match the master's `width`.
- `N_REQ`, 4: number of requesters; must be ≥2.
- `SS_W`, 2: slave-select code width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-low (0 = reset).
- `req` input N_REQ: per-requester transfer request, level; held until `done[i]`.
- `tx_data` input N_REQ*WIDTH: flattened words; slice i = `tx_data[i*WIDTH +: WIDTH]`.
- `tx_ss` input N_REQ*SS_W: flattened slave-select codes, same slicing.
- `gnt` output N_REQ: one-hot grant, high from LOAD through DONE.
- `done` output N_REQ: one-cycle completion pulse to the granted requester.
- `rx_data` output WIDTH: last received word, held until the next DONE.
- `busy` output 1: high in any state other than IDLE.
- `m_up_data` output 1: load strobe to the SPI master.
- `m_data` output WIDTH: word to the SPI master.
- `m_ss` output SS_W: slave-select code to the SPI master.
- `m_rx_data` input WIDTH: SPI master's shift register contents.

## Operation
- FSM states: IDLE → LOAD → SHIFT → DONE → IDLE.
- IDLE: when `req` is non-zero, latch the winner index, `tx_data` slice and `tx_ss` slice, then go to LOAD. Otherwise stay in IDLE.
- LOAD (1 cycle): `m_up_data`=1, `m_data`=latched word, `m_ss`=latched code. Clear the bit counter. Go to SHIFT.
- SHIFT: `m_up_data`=0, `m_ss` holds the latched code, counter increments every cycle. After exactly `WIDTH` cycles, go to DONE.
  - Counter width is `$clog2(WIDTH+1)` so the terminal count never wraps.
- DONE (1 cycle): register `m_rx_data` into `rx_data`, pulse `done[winner]`, go to IDLE.
- `gnt` and `m_ss` are driven only from the latched copies. Changes on `req`, `tx_data` or `tx_ss` after the IDLE sample have no effect on the running transfer.
- Abort is not supported. If `req[winner]` drops mid-transfer, the transfer still completes and `done` still pulses.
- Arbitration is evaluated only in IDLE, and `req` sampled in LOAD, SHIFT or DONE is ignored. A requester that is still asserting is therefore re-arbitrated on the first IDLE cycle after DONE.

## Timing
- Reset values: state IDLE, `gnt`=0, `done`=0, `rx_data`=0, `busy`=0, `m_up_data`=0, `m_data`=0, `m_ss`='1 (all-ones = no slave selected), counter 0, round-robin pointer N_REQ-1.
- Reset asserted mid-transfer: all outputs take reset values on the next edge. No `done` pulse is issued, and the master sees `m_up_data`=0 and `m_ss`='1.
- Cycle numbering: `req` is seen in IDLE at cycle 0.
  - Cycle 1: LOAD, `gnt`/`busy` rise.
  - Cycles 2 to WIDTH+1: SHIFT.
  - Cycle WIDTH+2: DONE, `done` high, `rx_data` valid.
  - Cycle WIDTH+3: IDLE.
- Request-to-done latency: WIDTH+2 cycles. Back-to-back transfer period: WIDTH+3 cycles.
- In IDLE, `m_ss`='1 and `m_data` holds its last value.
- Simultaneous requests are resolved by the arbitration policy (see Configuration), one winner per IDLE sample.

## Configuration
- `SPI_ARB_RR_EN` defined: round-robin arbitration.
  - The search starts at (pointer+1) mod N_REQ.
  - The pointer is updated to the winner index on IDLE→LOAD.
  - With the reset pointer at N_REQ-1, index 0 wins first.
- `SPI_ARB_RR_EN` undefined: fixed priority, lowest asserted index wins. The pointer logic is not compiled in.

## Structure
- Package `spi_pkg`:
  - `typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} spi_arb_state_t`.
  - `localparam` idle slave-select value (all-ones).
- Sub-module `spi_req_arbiter`:
  - Combinational: `req` plus pointer in, one-hot grant and index out.
  - Pointer register under `SPI_ARB_RR_EN`.
  - The FSM, counter and datapath latches live in `spi_arbiter`.

## Test plan
- Single request, WIDTH=8: `req`=0001, word 8'hA5, ss 2'b01 → `m_up_data` pulses at cycle 1 with `m_data`=A5 and `m_ss`=01. `done[0]` rises at cycle 10. `rx_data` equals the model's `m_rx_data` at that cycle, and `m_ss` returns to 11 at cycle 11.
- All four requesting continuously with RR enabled → grant order 0,1,2,3,0, with each `done` exactly 11 cycles apart.
- Same stimulus with the macro undefined → requester 0 wins every transfer.
- `req[2]` dropped at cycle 5 of its transfer → transfer completes and `done[2]` still pulses at cycle 10.
- `rst`=0 at cycle 6 of a transfer → next edge: `busy`=0, `gnt`=0, `m_ss`=11 and no `done` pulse. A new `req`=0010 after release completes normally in 10 cycles.
- `tx_data` changed during SHIFT → `m_data` and `m_ss` are unchanged until DONE.
